// File: rtl/me_result_serializer.sv
// Motion-estimation result serializer: one-entry hold buffer feeding a framed serial line.
// Optional ME_SER_PARITY_EN inserts an even-parity bit between the data and STOP bits.
module me_result_serializer #(
  parameter int MV_WIDTH  = 6,
  parameter int SAD_WIDTH = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [MV_WIDTH-1:0]  mv_x,
  input  logic [MV_WIDTH-1:0]  mv_y,
  input  logic [SAD_WIDTH-1:0] sad,
  output logic                 serial_out,
  output logic                 busy
);
  localparam int N  = 2*MV_WIDTH + SAD_WIDTH;
  localparam int BW = $clog2(N);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef ME_SER_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [7:0]    div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  shreg, hold_reg;
  logic          hold_full;
`ifdef ME_SER_PARITY_EN
  logic          parity_q;
`endif

  logic accept, bit_end, load;
  assign accept  = res_valid & res_ready;
  assign bit_end = (div_cnt == DIV_LAST);
  // Hold register drains into the shifter from IDLE or straight out of STOP (no idle gap).
  assign load    = hold_full & ((state == S_IDLE) | ((state == S_STOP) & bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      res_ready  <= 1'b1;
      hold_full  <= 1'b0;
      hold_reg   <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef ME_SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else if (init) begin
      state      <= S_IDLE;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      res_ready  <= 1'b1;
      hold_full  <= 1'b0;
      div_cnt    <= '0;
    end else begin
      if (accept) begin
        hold_reg  <= {mv_x, mv_y, sad};
        hold_full <= 1'b1;
        res_ready <= 1'b0;
      end
      if (load) begin
        shreg     <= hold_reg;
        hold_full <= 1'b0;
        res_ready <= 1'b1;
`ifdef ME_SER_PARITY_EN
        parity_q  <= ^hold_reg;
`endif
      end

      div_cnt <= bit_end ? 8'd0 : div_cnt + 8'd1;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (hold_full) begin
            state      <= S_START;
            serial_out <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_START: if (bit_end) begin
          state      <= S_DATA;
          bit_cnt    <= '0;
          serial_out <= shreg[N-1];
          shreg      <= shreg << 1;
        end
        S_DATA: if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
`ifdef ME_SER_PARITY_EN
            state      <= S_PARITY;
            serial_out <= parity_q;
`else
            state      <= S_STOP;
            serial_out <= 1'b0;
`endif
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            serial_out <= shreg[N-1];
            shreg      <= shreg << 1;
          end
        end
`ifdef ME_SER_PARITY_EN
        S_PARITY: if (bit_end) begin
          state      <= S_STOP;
          serial_out <= 1'b0;
        end
`endif
        S_STOP: if (bit_end) begin
          state      <= hold_full ? S_START : S_IDLE;
          serial_out <= hold_full;
          busy       <= hold_full;
        end
        default: begin
          state      <= S_IDLE;
          serial_out <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule
